// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and response signals between the issue logic, the
// sequencer and the ALU datapath.
interface alu_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [SHW-1:0]   req0_shamt;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [SHW-1:0]   req1_shamt;

    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_out;
    logic             alu_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin, req0_shamt,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin, req1_shamt,
        output req1_ready,
        output alu_sel, alu_a, alu_b, alu_cin,
        input  alu_out, alu_ovf,
        output rsp_valid, rsp_data, rsp_ovf, rsp_id, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_cin, req0_shamt,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin, req1_shamt,
        input  req1_ready,
        input  alu_sel, alu_a, alu_b, alu_cin,
        output alu_out, alu_ovf,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_id, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin front end for the 8-bit ALU: arbitrates two requesters, runs
// one op at a time (shifts iterated one bit per cycle) and returns a response.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic            clock,
    input logic            clear,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_NOT = 3'b101, OP_SHL = 3'b110, OP_SHR = 3'b111
    } op_e;

    state_e           state, state_nx;
    logic             last_grant;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, work, rsp_data_q;
    logic             cin_q, id_q, sflag, rsp_ovf_q;
    logic [SHW-1:0]   cnt;

    logic             grant0, grant1, accept;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin, sel_shift;
    logic [SHW-1:0]   sel_shamt;
    logic             shout, last_step;

    // Arbitration: on contention the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        accept    = grant0 | grant1;
        sel_op    = grant1 ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
        sel_a     = grant1 ? bus.req1_a     : bus.req0_a;
        sel_b     = grant1 ? bus.req1_b     : bus.req0_b;
        sel_cin   = grant1 ? bus.req1_cin   : bus.req0_cin;
        sel_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;
        sel_shift = (sel_op == OP_SHL) || (sel_op == OP_SHR);
    end

    assign shout     = (op_q == OP_SHL) ? work[WIDTH-1] : work[0];
    assign last_step = (cnt == SHW'(1));

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!sel_shift)          state_nx = EXEC;
                    else if (sel_shamt == '0) state_nx = DONE;
                    else                     state_nx = SHIFT;
                end
            end
            EXEC:    state_nx = DONE;
            SHIFT:   if (last_step) state_nx = DONE;
            DONE:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.alu_sel    = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_cin    = 1'b0;
        case (state)
            EXEC: begin
                bus.alu_sel = op_q;
                bus.alu_a   = a_q;
                bus.alu_b   = b_q;
                bus.alu_cin = (op_q == OP_ADD) ? cin_q : 1'b0;
            end
            SHIFT: begin
                bus.alu_sel = op_q;
                bus.alu_a   = work;
            end
            default: ;
        endcase
        bus.rsp_valid = (state == DONE);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_ovf   = rsp_ovf_q;
        bus.rsp_id    = id_q;
        bus.busy      = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            last_grant <= 1'b1;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            cnt        <= '0;
            work       <= '0;
            sflag      <= 1'b0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        cin_q      <= sel_cin;
                        id_q       <= grant1;
                        last_grant <= grant1;
                        cnt        <= sel_shamt;
                        work       <= sel_a;
                        sflag      <= 1'b0;
                        // A zero-length shift completes without touching the ALU.
                        if (sel_shift && sel_shamt == '0) begin
                            rsp_data_q <= sel_a;
                            rsp_ovf_q  <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q <= bus.alu_out;
                    rsp_ovf_q  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? bus.alu_ovf : 1'b0;
                end
                SHIFT: begin
                    work  <= bus.alu_out;
                    cnt   <= cnt - SHW'(1);
                    sflag <= sflag | shout;
                    if (last_step) begin
                        rsp_data_q <= bus.alu_out;
                        rsp_ovf_q  <= sflag | shout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a response
// scoreboard fed at command acceptance.
module tb_alu_sequencer;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_sequencer_if #(.WIDTH(8), .SHW(3)) bus();
    alu_sequencer #(.WIDTH(8), .SHW(3)) dut (.clock(clock), .clear(clear), .bus(bus));

    always_comb begin
        bus.alu_out = '0;
        bus.alu_ovf = 1'b0;
        case (bus.alu_sel)
            3'b000: {bus.alu_ovf, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
            3'b001: begin bus.alu_out = bus.alu_a - bus.alu_b; bus.alu_ovf = (bus.alu_a < bus.alu_b); end
            3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b101: bus.alu_out = ~bus.alu_a;
            3'b110: bus.alu_out = {bus.alu_a[6:0], 1'b0};
            default: bus.alu_out = {1'b0, bus.alu_a[7:1]};
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       id;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    int tests = 0;
    int fails = 0;
    int tb_last = 1;
    int g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic [2:0] sh, input logic id);
        exp_t e;
        logic [8:0] r;
        logic [7:0] w;
        e.id = id;
        e.ovf = 1'b0;
        e.lat = 1;
        case (op)
            3'd0: begin r = {1'b0, a} + {1'b0, b} + {8'h00, cin}; e.data = r[7:0]; e.ovf = r[8]; end
            3'd1: begin r = {1'b0, a} - {1'b0, b}; e.data = r[7:0]; e.ovf = r[8]; end
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = a ^ b;
            3'd5: e.data = ~a;
            default: begin
                w = a;
                for (int unsigned i = 0; i < sh; i++) begin
                    if (op == 3'd6) begin e.ovf |= w[7]; w = w << 1; end
                    else            begin e.ovf |= w[0]; w = w >> 1; end
                end
                e.data = w;
                e.lat = int'(sh);
            end
        endcase
        return e;
    endfunction

    task automatic set_req(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [2:0] sh);
        if (r == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_shamt = sh;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_shamt = sh;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_rsp_ovf"}, bus.rsp_ovf, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_alu_sel"}, bus.alu_sel, 0);
        check({tag, "_alu_a"}, bus.alu_a, 0);
        check({tag, "_alu_b"}, bus.alu_b, 0);
        check({tag, "_alu_cin"}, bus.alu_cin, 0);
        check({tag, "_ready"}, {bus.req0_ready, bus.req1_ready}, 0);
    endtask

    // Called on a negedge; returns on the negedge after the acceptance edge.
    task automatic grant_step(input bit v0, input bit v1, input bit keep, output int gid);
        int expg;
        exp_t e;
        gid = -1;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                check("one_grant", {bus.req0_ready, bus.req1_ready} == 2'b11, 0);
                gid = bus.req1_ready ? 1 : 0;
                expg = (v0 && v1) ? (tb_last == 1 ? 0 : 1) : (v1 ? 1 : 0);
                check("grant", gid, expg);
                if (expg == 0) e = model(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_shamt, 1'b0);
                else           e = model(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_shamt, 1'b1);
                sbq.push_back(e);
                tb_last = expg;
                @(posedge clock);
                @(negedge clock);
                if (!keep) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
                return;
            end
            @(negedge clock);
        end
        check("grant_timeout", 0, 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int n = 0;
        if (sbq.size() == 0) begin check("sb_empty", 0, 1); return; end
        e = sbq.pop_front();
        while (!bus.rsp_valid && n < 40) begin @(negedge clock); n++; end
        check("latency", n, e.lat);
        if (!bus.rsp_valid) return;
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_ovf", bus.rsp_ovf, e.ovf);
        check("rsp_id", bus.rsp_id, e.id);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_data", {bus.rsp_id, bus.rsp_ovf, bus.rsp_data}, {e.id, e.ovf, e.data});
            check("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            check("bp_busy", bus.busy, 1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("post_valid", bus.rsp_valid, 0);
        check("post_busy", bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        clear = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        set_req(0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
        set_req(1, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
        @(negedge clock);
        @(negedge clock);
        check_reset("rst");
        clear = 1'b0;
        @(negedge clock);

        // Arithmetic
        set_req(0, 3'd0, 8'h01, 8'h00, 1'b0, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd0, 8'hFF, 8'h01, 1'b0, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd1, 8'h01, 8'hAA, 1'b0, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd0, 8'h10, 8'h20, 1'b1, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd1, 8'h10, 8'h20, 1'b1, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(1, 3'd4, 8'h5A, 8'hFF, 1'b0, 3'd0); grant_step(0, 1, 0, g); check("req1_only", g, 1); collect(0);

        // Round robin with a lone req1 command in between
        set_req(0, 3'd2, 8'hA0, 8'h2C, 1'b0, 3'd0);
        set_req(1, 3'd3, 8'hA0, 8'h2C, 1'b0, 3'd0);
        grant_step(1, 1, 0, g); check("rr_order0", g, 0); collect(0);
        grant_step(1, 1, 0, g); check("rr_order1", g, 1); collect(0);
        set_req(1, 3'd5, 8'h3C, 8'h00, 1'b0, 3'd0);
        grant_step(0, 1, 0, g); check("rr_lone1", g, 1); collect(0);
        set_req(1, 3'd3, 8'hA0, 8'h2C, 1'b0, 3'd0);
        grant_step(1, 1, 0, g); check("rr_order2", g, 0); collect(0);
        grant_step(1, 1, 0, g); check("rr_order3", g, 1); collect(0);

        // Iterative shifts
        set_req(0, 3'd6, 8'b00001111, 8'h00, 1'b0, 3'd3); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd6, 8'b00001111, 8'h00, 1'b0, 3'd5); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd7, 8'b10110000, 8'h00, 1'b0, 3'd0); grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd7, 8'h81, 8'h00, 1'b0, 3'd7);       grant_step(1, 0, 0, g); collect(0);
        set_req(0, 3'd6, 8'h40, 8'h00, 1'b0, 3'd1);       grant_step(1, 0, 0, g); collect(0);

        // Backpressure with both requesters waiting
        set_req(0, 3'd0, 8'h33, 8'h44, 1'b0, 3'd0);
        set_req(1, 3'd1, 8'h50, 8'h60, 1'b0, 3'd0);
        grant_step(1, 1, 1, g); check("bp_grant", g, 1); collect(3);
        grant_step(1, 1, 0, g); check("bp_next", g, 0); collect(0);

        // Clear in the middle of a long shift
        set_req(0, 3'd6, 8'h01, 8'h00, 1'b0, 3'd6);
        grant_step(1, 0, 0, g);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check_reset("midclr");
        clear = 1'b0;
        sbq.delete();
        tb_last = 1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_clear", seen, 0);
        set_req(0, 3'd4, 8'h0F, 8'hF0, 1'b0, 3'd0);
        set_req(1, 3'd2, 8'h0F, 8'hF0, 1'b0, 3'd0);
        grant_step(1, 1, 0, g); check("post_clear_grant", g, 0); collect(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
